// File: rtl/multi_axis_stepper.sv
// N-axis step/direction generator: per-axis rate-limited, limit-checked step pulses
// with direction-setup time and a saturating position counter.
module multi_axis_stepper #(
  parameter int unsigned NUM_AXES  = 3,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned STEP_DIV  = 50000,
  parameter int unsigned PULSE_W   = 500,
  parameter int unsigned DIR_SETUP = 250
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_AXES-1:0]       cmd_pos,
  input  logic [NUM_AXES-1:0]       cmd_neg,
  input  logic [NUM_AXES-1:0]       pos_enable,
  input  logic [NUM_AXES-1:0]       neg_enable,
  input  logic                      global_enable,
  input  logic [NUM_AXES*POS_W-1:0] upper_limit,
  input  logic [NUM_AXES-1:0]       home,
  output logic [NUM_AXES-1:0]       step,
  output logic [NUM_AXES-1:0]       dir,
  output logic [NUM_AXES*POS_W-1:0] position,
  output logic [NUM_AXES-1:0]       at_upper,
  output logic [NUM_AXES-1:0]       at_lower,
  output logic [NUM_AXES-1:0]       busy
);

  localparam int unsigned MAX_CNT = (STEP_DIV > DIR_SETUP) ? STEP_DIV : DIR_SETUP;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [POS_W-1:0] pos, pos_nx, lim;
    logic             step_r, step_nx, dir_r, dir_nx, busy_r;
    logic             pos_req, neg_req, same_req, opp_req, done, start;

    assign lim      = upper_limit[i*POS_W +: POS_W];
    assign pos_req  = global_enable & pos_enable[i] & cmd_pos[i] & ~cmd_neg[i] & (pos < lim);
    assign neg_req  = global_enable & neg_enable[i] & cmd_neg[i] & ~cmd_pos[i] & (pos != '0);
    assign same_req = dir_r ? pos_req : neg_req;
    assign opp_req  = dir_r ? neg_req : pos_req;
    assign done     = (cnt == '0);

    // Next-state: a started pulse always runs PULSE then HOLD to completion.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      step_nx  = step_r;
      dir_nx   = dir_r;
      pos_nx   = pos;
      start    = 1'b0;
      unique case (state)
        IDLE: begin
          if (same_req) begin
            start = 1'b1;
          end else if (opp_req) begin
            dir_nx   = ~dir_r;
            state_nx = SETUP;
            cnt_nx   = CNT_W'(DIR_SETUP - 1);
          end
        end
        SETUP: begin
          if (opp_req) begin
            dir_nx = ~dir_r;
            cnt_nx = CNT_W'(DIR_SETUP - 1);
          end else if (done) begin
            if (same_req) start = 1'b1;
            else state_nx = IDLE;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        PULSE: begin
          if (done) begin
            step_nx  = 1'b0;
            state_nx = HOLD;
            cnt_nx   = CNT_W'(STEP_DIV - PULSE_W - 1);
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        HOLD: begin
          if (done) begin
            if (same_req) begin
              start = 1'b1;
            end else if (opp_req) begin
              dir_nx   = ~dir_r;
              state_nx = SETUP;
              cnt_nx   = CNT_W'(DIR_SETUP - 1);
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
      if (start) begin
        state_nx = PULSE;
        step_nx  = 1'b1;
        cnt_nx   = CNT_W'(PULSE_W - 1);
        pos_nx   = dir_r ? pos + 1'b1 : pos - 1'b1;
      end
      // Home wins over a same-edge position step.
      if (home[i]) pos_nx = '0;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state  <= IDLE;
        cnt    <= '0;
        step_r <= 1'b0;
        dir_r  <= 1'b0;
        pos    <= '0;
        busy_r <= 1'b0;
      end else begin
        state  <= state_nx;
        cnt    <= cnt_nx;
        step_r <= step_nx;
        dir_r  <= dir_nx;
        pos    <= pos_nx;
        busy_r <= (state_nx != IDLE);
      end
    end

    assign step[i]                    = step_r;
    assign dir[i]                     = dir_r;
    assign busy[i]                    = busy_r;
    assign position[i*POS_W +: POS_W] = pos;
    assign at_upper[i]                = (pos >= lim);
    assign at_lower[i]                = (pos == '0);
  end

endmodule

// File: tb/tb_multi_axis_stepper.sv
// Directed bench for multi_axis_stepper: per-cycle vector table for a single-axis run,
// plus hand-written sequences for limits, reversal, enables, reset mid-pulse and home.
module tb_multi_axis_stepper;
  localparam int unsigned NA = 3;
  localparam int unsigned PW = 16;
  localparam int unsigned NV = 45;

  logic             clk = 1'b0;
  logic             reset;
  logic [NA-1:0]    cmd_pos, cmd_neg, pos_enable, neg_enable, home;
  logic             global_enable;
  logic [NA*PW-1:0] upper_limit;
  logic [NA-1:0]    step, dir, at_upper, at_lower, busy;
  logic [NA*PW-1:0] position;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cp;
    logic        st;
    logic        dr;
    logic [15:0] ps;
    logic        bz;
  } vec_t;

  vec_t vecs [NV];

  multi_axis_stepper #(
    .NUM_AXES(NA), .POS_W(PW), .STEP_DIV(8), .PULSE_W(2), .DIR_SETUP(3)
  ) dut (
    .clk(clk), .reset(reset), .cmd_pos(cmd_pos), .cmd_neg(cmd_neg),
    .pos_enable(pos_enable), .neg_enable(neg_enable), .global_enable(global_enable),
    .upper_limit(upper_limit), .home(home), .step(step), .dir(dir),
    .position(position), .at_upper(at_upper), .at_lower(at_lower), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pos_of(input int a);
    return position[a*PW +: PW];
  endfunction

  initial begin
    int rises;
    int saw_step;
    int saw_busy;
    int found;
    logic prev;

    // Single-axis run: record k is applied for edge Ek and sampled just after it.
    for (int k = 0; k < int'(NV); k++) begin
      int p;
      p = (k < 3) ? 0 : ((k - 3) / 8 + 1);
      if (p > 5) p = 5;
      vecs[k].cp = (k <= 39);
      vecs[k].st = (k >= 3 && k <= 36 && ((k - 3) % 8) < 2);
      vecs[k].dr = 1'b1;
      vecs[k].ps = 16'(p);
      vecs[k].bz = (k <= 42);
    end

    reset         = 1'b0;
    cmd_pos       = '0;
    cmd_neg       = '0;
    pos_enable    = '1;
    neg_enable    = '1;
    home          = '0;
    global_enable = 1'b1;
    for (int a = 0; a < int'(NA); a++) upper_limit[a*PW +: PW] = 16'd2600;

    tick();
    tick();
    chk("rst_step", 64'(step), 64'(0));
    chk("rst_dir", 64'(dir), 64'(0));
    chk("rst_position", 64'(position), 64'(0));
    chk("rst_at_lower", 64'(at_lower), 64'(3'b111));
    chk("rst_at_upper", 64'(at_upper), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b1;

    for (int k = 0; k < int'(NV); k++) begin
      cmd_pos[0] = vecs[k].cp;
      tick();
      chk($sformatf("t1_step[%0d]", k), 64'(step[0]), 64'(vecs[k].st));
      chk($sformatf("t1_dir[%0d]", k), 64'(dir[0]), 64'(vecs[k].dr));
      chk($sformatf("t1_pos[%0d]", k), 64'(pos_of(0)), 64'(vecs[k].ps));
      chk($sformatf("t1_busy[%0d]", k), 64'(busy[0]), 64'(vecs[k].bz));
      chk($sformatf("t1_others[%0d]", k), 64'(step[2:1]), 64'(0));
    end
    chk("t1_pos1", 64'(pos_of(1)), 64'(0));
    chk("t1_pos2", 64'(pos_of(2)), 64'(0));

    // Upper limit on axis 1, then reversal down to zero.
    upper_limit[1*PW +: PW] = 16'd3;
    cmd_pos[1] = 1'b1;
    rises = 0;
    saw_step = 0;
    prev = step[1];
    for (int n = 0; n < 60; n++) begin
      tick();
      if (step[1] && !prev) rises++;
      if (step[1]) saw_step++;
      prev = step[1];
    end
    chk("t2_up_rises", 64'(rises), 64'(3));
    chk("t2_up_high_cycles", 64'(saw_step), 64'(6));
    chk("t2_up_pos", 64'(pos_of(1)), 64'(3));
    chk("t2_at_upper", 64'(at_upper[1]), 64'(1));
    chk("t2_up_busy", 64'(busy[1]), 64'(0));

    cmd_pos[1] = 1'b0;
    cmd_neg[1] = 1'b1;
    tick();
    chk("t2_dir_fall", 64'(dir[1]), 64'(0));
    chk("t2_setup_busy", 64'(busy[1]), 64'(1));
    chk("t2_setup_step0", 64'(step[1]), 64'(0));
    tick();
    chk("t2_setup_step1", 64'(step[1]), 64'(0));
    tick();
    chk("t2_setup_step2", 64'(step[1]), 64'(0));
    tick();
    chk("t2_first_down_step", 64'(step[1]), 64'(1));
    chk("t2_first_down_pos", 64'(pos_of(1)), 64'(2));
    rises = 1;
    prev = step[1];
    for (int n = 0; n < 40; n++) begin
      tick();
      if (step[1] && !prev) rises++;
      prev = step[1];
    end
    chk("t2_down_rises", 64'(rises), 64'(3));
    chk("t2_down_pos", 64'(pos_of(1)), 64'(0));
    chk("t2_at_lower", 64'(at_lower[1]), 64'(1));
    chk("t2_down_busy", 64'(busy[1]), 64'(0));
    cmd_neg[1] = 1'b0;
    upper_limit[1*PW +: PW] = 16'd2600;

    // Conflicting commands, then global disable, on axis 2.
    saw_step = 0;
    saw_busy = 0;
    cmd_pos[2] = 1'b1;
    cmd_neg[2] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (step[2]) saw_step++;
      if (busy[2]) saw_busy++;
    end
    chk("t3_both_step", 64'(saw_step), 64'(0));
    chk("t3_both_busy", 64'(saw_busy), 64'(0));
    cmd_neg[2] = 1'b0;
    global_enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (step[2]) saw_step++;
      if (busy[2]) saw_busy++;
    end
    chk("t3_gdis_step", 64'(saw_step), 64'(0));
    chk("t3_gdis_busy", 64'(saw_busy), 64'(0));
    chk("t3_pos2", 64'(pos_of(2)), 64'(0));
    cmd_pos[2] = 1'b0;
    global_enable = 1'b1;

    // Reset clears axis 0 (at position 5); at_upper follows a zero limit.
    reset = 1'b0;
    tick();
    tick();
    chk("t4_rst_pos0", 64'(pos_of(0)), 64'(0));
    chk("t4_rst_dir", 64'(dir), 64'(0));
    upper_limit[2*PW +: PW] = 16'd0;
    #1;
    chk("t4_at_upper_zero_lim", 64'(at_upper), 64'(3'b100));
    upper_limit[2*PW +: PW] = 16'd2600;
    reset = 1'b1;

    // Reset during the second cycle of a pulse at position 4.
    cmd_pos[0] = 1'b1;
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      tick();
      if (pos_of(0) == 16'd4 && step[0]) found = 1;
    end
    chk("t4_reach_pos4", 64'(found), 64'(1));
    tick();
    chk("t4_pulse_2nd_cycle", 64'(step[0]), 64'(1));
    reset = 1'b0;
    tick();
    chk("t4_mid_step", 64'(step[0]), 64'(0));
    chk("t4_mid_pos", 64'(pos_of(0)), 64'(0));
    chk("t4_mid_busy", 64'(busy[0]), 64'(0));
    cmd_pos[0] = 1'b0;
    tick();
    reset = 1'b1;

    // Home on the same edge as a step rise from position 7.
    cmd_pos[0] = 1'b1;
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      tick();
      if (pos_of(0) == 16'd7) found = 1;
    end
    chk("t5_reach_pos7", 64'(found), 64'(1));
    for (int n = 0; n < 7; n++) tick();
    chk("t5_pre_step", 64'(step[0]), 64'(0));
    chk("t5_pre_pos", 64'(pos_of(0)), 64'(7));
    home[0] = 1'b1;
    tick();
    chk("t5_home_step", 64'(step[0]), 64'(1));
    chk("t5_home_pos", 64'(pos_of(0)), 64'(0));
    home[0] = 1'b0;
    cmd_pos[0] = 1'b0;
    tick();
    chk("t5_pulse_cont", 64'(step[0]), 64'(1));
    chk("t5_pos_held", 64'(pos_of(0)), 64'(0));
    tick();
    chk("t5_pulse_end", 64'(step[0]), 64'(0));
    chk("t5_pos_final", 64'(pos_of(0)), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_axis_stepper.md
# multi_axis_stepper

Parametrised N-axis step/direction generator, successor to the fixed three-axis motion block. Each axis turns a pair of direction commands (from the NES controller decoder or firmware) into rate-limited, limit-checked step pulses with guaranteed direction-setup time. It also tracks a saturating position counter per axis. Sits between command decode and the stepper driver pins; position outputs feed the display and host logic.

## Interface
- NUM_AXES, 3, number of independent axes
- POS_W, 16, position counter / limit width (unsigned)
- STEP_DIV, 50000, clock cycles per step period at full rate; must be > PULSE_W
- PULSE_W, 500, step-high width in cycles; ≥1
- DIR_SETUP, 250, cycles dir is held stable before step rises after a direction change; ≥1
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge, priority over everything
- cmd_pos  in  NUM_AXES  per-axis request to move in + direction (level)
- cmd_neg  in  NUM_AXES  per-axis request to move in − direction (level)
- pos_enable  in  NUM_AXES  per-axis permit for + motion
- neg_enable  in  NUM_AXES  per-axis permit for − motion
- global_enable  in  1  master permit, all axes
- upper_limit  in  NUM_AXES*POS_W  flat per-axis upper soft limit, axis i at [i*POS_W +: POS_W]
- home  in  NUM_AXES  per-axis position clear (level)
- step  out  NUM_AXES  registered step pulses
- dir  out  NUM_AXES  registered direction, 1 = +
- position  out  NUM_AXES*POS_W  registered per-axis position, same packing as upper_limit
- at_upper  out  NUM_AXES  combinational: position ≥ upper_limit
- at_lower  out  NUM_AXES  combinational: position == 0
- busy  out  NUM_AXES  registered: axis FSM not IDLE

## Operation
- Per axis, evaluated every cycle: pos_req = global_enable & pos_enable & cmd_pos & ~cmd_neg & (position < upper_limit); neg_req = global_enable & neg_enable & cmd_neg & ~cmd_pos & (position != 0). Both commands high → no request.
- FSM states: IDLE, SETUP, PULSE, HOLD; one down-counter per axis.
- IDLE: if the request direction equals dir → PULSE. If the request is opposite to dir → dir flips this edge, → SETUP. No request → stay.
- SETUP: held DIR_SETUP cycles, then → PULSE if the request in dir still holds, else IDLE. A reversed request here restarts SETUP with dir flipped.
- Entry into PULSE: step←1; position ±1 on the same edge.
- PULSE: PULSE_W cycles, then step←0 → HOLD.
- HOLD: STEP_DIV−PULSE_W cycles. At its final edge, re-evaluate: same-direction request → PULSE (back-to-back period exactly STEP_DIV); opposite request → dir flips, SETUP; none → IDLE.
- A started pulse always completes its PULSE and HOLD, even if the request, enable or limit drops.
- Position never wraps: + blocked at upper_limit, − blocked at 0. If upper_limit is lowered below position, + is blocked, − is allowed, and position is not altered.
- home[i]: position←0 at the next edge; priority over a same-edge increment. FSM and step are unaffected.
- Reset (reset==0 at an edge): all axes IDLE; step, dir, busy, position and counters all 0. at_lower all 1; at_upper is 1 only where upper_limit==0.

## Timing
- Request change → dir change: 1 edge (IDLE or end of HOLD).
- Same-direction start from IDLE: step rises on the first edge seeing the request.
- Reversal: step rises DIR_SETUP edges after dir changes.
- Step high exactly PULSE_W cycles; rising-edge spacing ≥ STEP_DIV cycles.
- position changes only on the step rising edge, on home, or on reset.
- Reset mid-pulse: step low the following cycle; no partial state retained.
- Axes are fully independent; simultaneous events on different axes never interact.

## Test plan
(Bench parameters: NUM_AXES=3, POS_W=16, STEP_DIV=8, PULSE_W=2, DIR_SETUP=3; all enables 1, upper_limit=2600 unless stated.)
- Reset held 2 cycles → step=0, dir=0, position=0, at_lower=3'b111, busy=0.
- cmd_pos[0] high for edges E0–E39 → dir[0]=1 at E0; step[0] rises at E3, E11, E19, E27, E35, each 2 cycles high; final position[0]=5; IDLE at E43. Axes 1 and 2 stay still.
- upper_limit[1]=3, cmd_pos[1] held 60 cycles → exactly 3 pulses, position[1]=3, at_upper[1]=1. Then cmd_neg[1] → dir falls, first step 3 cycles later, position counts down to 0, at_lower[1]=1, no further pulses.
- cmd_pos[2] and cmd_neg[2] both high, then global_enable=0 with cmd_pos[2] only → no step[2], busy[2]=0.
- Reset asserted at the 2nd cycle of a PULSE on axis 0 at position 4 → next cycle step[0]=0, position[0]=0, busy[0]=0.
- home[0] asserted on the same edge step[0] rises from position 7 → position[0]=0; the pulse still completes 2 cycles high.
